// File: rtl/wb_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter_if
//   Bundles the four-master / one-slave Wishbone signals that surround
//   wb_rr_arbiter.
//
//   Master-side vectors (master k owns slice k):
//     m_adr_i[128], m_dat_i[128], m_sel_i[16], m_we_i/m_cyc_i/m_stb_i[4]
//     m_dat_o[32] (shared read data), m_ack_o[4], m_err_o[4]
//   Slave-side:
//     s_adr_o[32], s_dat_o[32], s_sel_o[4], s_we_o, s_cyc_o, s_stb_o
//     s_dat_i[32], s_ack_i
//   Status:
//     gnt_o[4] one-hot grant, timeout_o watchdog pulse
//
//   Modports:
//     arb    - the arbiter itself
//     master - the bus masters (drive requests, receive terminations)
//     slave  - the shared slave (receives request, drives response)
// ----------------------------------------------------------------------------
interface wb_rr_arbiter_if;
    logic [127:0] m_adr_i;
    logic [127:0] m_dat_i;
    logic [15:0]  m_sel_i;
    logic [3:0]   m_we_i;
    logic [3:0]   m_cyc_i;
    logic [3:0]   m_stb_i;
    logic [31:0]  m_dat_o;
    logic [3:0]   m_ack_o;
    logic [3:0]   m_err_o;

    logic [31:0]  s_adr_o;
    logic [31:0]  s_dat_o;
    logic [3:0]   s_sel_o;
    logic         s_we_o;
    logic         s_cyc_o;
    logic         s_stb_o;
    logic [31:0]  s_dat_i;
    logic         s_ack_i;

    logic [3:0]   gnt_o;
    logic         timeout_o;

    modport arb (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        input  s_dat_i, s_ack_i,
        output gnt_o, timeout_o
    );

    modport master (
        output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
        input  m_dat_o, m_ack_o, m_err_o, gnt_o, timeout_o
    );

    modport slave (
        input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
        output s_dat_i, s_ack_i
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wb_rr_arbiter
//   Four-master, single-slave Wishbone arbiter. Grants are handed out
//   round-robin and held for the winner's whole cyc period. A watchdog turns
//   a slave that never acknowledges into a one-cycle err to the granted
//   master, after which the grant is kept until that master drops cyc.
//
//   Parameters:
//     timeout - slave wait cycles before err (0 disables, 0..65535)
//   Ports:
//     clk   - system clock, rising edge
//     reset - asynchronous active-high reset
//     bus   - wb_rr_arbiter_if.arb, all master/slave/status signals
// ----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int unsigned timeout = 1024
) (
    input  logic           clk,
    input  logic           reset,
    wb_rr_arbiter_if.arb   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        ERR     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic        WD_EN   = (timeout != 0);
    localparam logic [15:0] WD_LAST = (timeout == 0) ? 16'd0 : 16'(timeout - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q,   gnt_d;
    logic [1:0]  idx_q,   idx_d;    // index of the granted master
    logic [1:0]  last_q,  last_d;   // most recent winner, round-robin pointer
    logic [15:0] wcnt_q,  wcnt_d;

    logic [3:0]  req;
    logic        g_cyc;
    logic        g_stb;
    logic        g_we;
    logic        wd_expire;

    // Round-robin pick: search last+1, last+2, last+3, last. Iterating from
    // the farthest candidate down lets the nearest requester overwrite.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] win;
        logic [1:0] cand;
        win = last;
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (r[cand]) win = cand;
        end
        return win;
    endfunction

    assign req   = bus.m_cyc_i & bus.m_stb_i;
    assign g_cyc = bus.m_cyc_i[idx_q];
    assign g_stb = bus.m_stb_i[idx_q];
    assign g_we  = bus.m_we_i[idx_q];

    // In BUSY the slave strobe equals the granted strobe, so g_stb stands in
    // for s_stb_o here and keeps the expiry free of an output feedback path.
    assign wd_expire = WD_EN && (state_q == BUSY) && g_stb && !bus.s_ack_i
                       && (wcnt_q == WD_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            last_q  <= 2'd3;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d   = rr_pick(req, last_q);
                    last_d  = idx_d;
                    gnt_d   = 4'b0001 << idx_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Dropping cyc takes precedence over a pending expiry.
                if (!g_cyc) begin
                    gnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (wd_expire) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!g_cyc) begin
                    gnt_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase

        // Watchdog counts consecutive unanswered strobe cycles of the grant.
        if (!WD_EN || (state_q != BUSY) || !g_stb || bus.s_ack_i)
            wcnt_d = 16'd0;
        else
            wcnt_d = wcnt_q + 16'd1;
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        logic busy;
        logic granted;
        busy    = (state_q == BUSY);
        granted = |gnt_q;

        bus.gnt_o     = gnt_q;
        bus.timeout_o = (state_q == ERR);

        bus.s_cyc_o   = busy & g_cyc;
        bus.s_stb_o   = busy & g_stb;
        bus.s_we_o    = busy & g_we;

        bus.s_adr_o   = granted ? bus.m_adr_i[{idx_q, 5'd0} +: 32] : 32'd0;
        bus.s_dat_o   = granted ? bus.m_dat_i[{idx_q, 5'd0} +: 32] : 32'd0;
        bus.s_sel_o   = granted ? bus.m_sel_i[{idx_q, 2'd0} +: 4]  : 4'd0;

        // Ack is routed only while BUSY; a late ack during ERR is dropped.
        bus.m_ack_o   = (busy && bus.s_ack_i) ? gnt_q : 4'd0;
        bus.m_err_o   = (state_q == ERR) ? gnt_q : 4'd0;
        bus.m_dat_o   = bus.s_dat_i;
    end

endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Four-master, single-slave Wishbone arbiter with round-robin grant and a bus-timeout watchdog. It sits between up to four bus masters (LM32 instruction/data ports, future DMA engines) and one shared slave port, in front of a conbus slave or a single peripheral. It holds each grant for a master's whole `cyc` period. A slave that never acknowledges produces a one-cycle `err` to the master instead of hanging the CPU.

## Interface
Parameters:
- `timeout`, default 1024: slave wait cycles before `err`. 0 disables the watchdog. Legal range 0..65535.

Ports:
- `clk` in 1: system clock. All logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m_adr_i` in 128: master addresses. Master k uses bits [32k+31:32k]. The same slicing applies to every `m_*` vector.
- `m_dat_i` in 128: master write data.
- `m_sel_i` in 16: master byte selects, 4 bits per master.
- `m_we_i`, `m_cyc_i`, `m_stb_i` in 4: per-master controls.
- `m_dat_o` out 32: read data, shared by all masters and driven from `s_dat_i`.
- `m_ack_o`, `m_err_o` out 4: per-master terminations.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1: slave-side request.
- `s_dat_i` in 32, `s_ack_i` in 1: slave response.
- `gnt_o` out 4: one-hot current grant. All zero when no master is granted.
- `timeout_o` out 1: one-cycle pulse in the `err` cycle.

## Operation
- States: IDLE, BUSY, ERR, RELEASE.
- IDLE:
  - Request vector is `m_cyc_i & m_stb_i`.
  - If it is non-zero, pick a master by round-robin. The search order starts at `last+1` mod 4.
  - Set `gnt_o` one-hot to the winner, set `last` to the winner, go to BUSY.
  - `last` resets to 3, so m0 wins first after reset.
- BUSY:
  - Slave outputs are muxed combinationally from the granted master.
  - `s_cyc_o`/`s_stb_o` equal the granted master's `cyc`/`stb`.
  - `s_ack_i` is routed only to the granted master's `m_ack_o` bit.
  - If the granted master's `cyc` is low at the clock edge, clear `gnt_o` and go to IDLE.
  - Other masters' `cyc`/`stb` are ignored. Their `ack`/`err` stay 0.
- Watchdog (active only when `timeout` != 0), 16-bit counter `wcnt`:
  - Cleared when not in BUSY, when `s_stb_o`=0, or when `s_ack_i`=1.
  - Otherwise incremented each cycle.
  - When `wcnt` == `timeout`-1, `s_stb_o`=1 and `s_ack_i`=0 at an edge, go to ERR.
- ERR (exactly one cycle):
  - `m_err_o`[granted]=1 and `timeout_o`=1.
  - `s_cyc_o`=`s_stb_o`=0.
  - A late `s_ack_i` in this cycle is dropped, not forwarded.
  - Next state is RELEASE.
- RELEASE:
  - Slave outputs are idle and the grant is still held.
  - Go to IDLE on the first edge where the granted `cyc` is low.
- In IDLE, ERR and RELEASE, `s_cyc_o`, `s_stb_o`, `s_we_o` are 0 and `m_ack_o` is 0.
- `s_adr_o`, `s_dat_o`, `s_sel_o` are 0 when nothing is granted.

## Timing
- Reset (asynchronous): state IDLE, `gnt_o`=0, `last`=3, `wcnt`=0, `timeout_o`=0. All `m_ack_o`/`m_err_o`/`s_*` outputs are 0 immediately.
- Reset in the middle of a transfer aborts it with no `ack`/`err`.
- Grant latency: a request present at edge t drives `gnt_o` and the slave request from cycle t+1. This is one added cycle per arbitration.
- Acknowledge path is combinational. `m_ack_o` follows `s_ack_i` in the same cycle.
- Back-to-back:
  - A granted master keeping `cyc` high across several `stb` strobes (burst, RMW) keeps the grant.
  - After release there is one IDLE cycle before the next grant.
- Simultaneous events:
  - `s_ack_i`=1 in the cycle the watchdog would expire: the ack wins, `wcnt` clears, no `err`.
  - All four masters request together: grant order m0, m1, m2, m3, m0, ...
- With `timeout`=1, `err` is asserted in the cycle after the first unacknowledged strobe cycle.

## Test plan
- Reset, then m1 only issues a write to 0x20000004 with data 0x5A and a slave acking after 2 cycles -> `gnt_o`=0010 one cycle after the request; slave sees adr 0x20000004, we=1; `m_ack_o`=0010 for one cycle; `gnt_o` returns to 0 after m1 drops `cyc`.
- All four masters hold single-read requests continuously with a slave acking immediately -> grants occur in order 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle; no master is starved.
- m0 holds `cyc` across three strobes while m2 requests -> m2 is not granted until m0's `cyc` drops; m2 is then granted one idle cycle later.
- `timeout`=8, slave never acks, m3 reads -> `m_err_o`=1000 and `timeout_o`=1 in exactly the 9th cycle after the strobe is first seen by the slave; `s_stb_o`=0 in that cycle; `gnt_o` holds until m3 drops `cyc`.
- `timeout`=8, slave acks on the 8th wait cycle -> `m_ack_o` asserts; no `err`, no `timeout_o`.
- Assert `reset` while m0 is granted and the slave is waiting -> `gnt_o`, `s_cyc_o`, `s_stb_o` go to 0 without waiting for a clock edge; after release the first grant goes to m0.
